// File: rtl/binary_to_bcd_converter_pkg.sv
// -----------------------------------------------------------------------------
// binary_to_bcd_converter_pkg
// Shared definitions for the serial binary-to-BCD converter:
//   state_t          - controller state encoding (IDLE, SHIFT, FINISH)
//   BCD_BLANK_DIGIT  - code driven on blanked leading-zero digits
//   BCD_SAT_DIGIT    - digit value used to saturate the display on overflow
// -----------------------------------------------------------------------------
package binary_to_bcd_converter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  localparam logic [3:0] BCD_BLANK_DIGIT = 4'hF;
  localparam logic [3:0] BCD_SAT_DIGIT   = 4'h9;

endpackage : binary_to_bcd_converter_pkg

// File: rtl/binary_to_bcd_converter_bcd_add3_digit.sv
// -----------------------------------------------------------------------------
// bcd_add3_digit
// Double-dabble correction for one BCD digit: adds 3 when the digit is 5 or
// more, so the following left shift carries correctly into the next digit.
//   digit     in   4  working BCD digit before the shift
//   adjusted  out  4  corrected digit
// -----------------------------------------------------------------------------
module bcd_add3_digit (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule : bcd_add3_digit

// File: rtl/binary_to_bcd_converter.sv
// -----------------------------------------------------------------------------
// binary_to_bcd_converter
// Serial shift-and-add-3 converter, one binary bit per clock, MSB first.
// A conversion takes BIN_WIDTH+1 edges after the accepting edge; the result is
// saturated to all nines on overflow and can optionally blank leading zeros.
//   CLK       in   1               clock, rising edge
//   RESET_N   in   1               asynchronous active-low reset
//   BIN_IN    in   BIN_WIDTH       unsigned value, sampled on the accepting edge
//   START     in   1               conversion request, accepted only in IDLE
//   BUSY      out  1               conversion in progress
//   DONE      out  1               one-cycle pulse, result valid from here on
//   BCD_OUT   out  BCD_DIGITS*4    packed BCD result, digit 0 in bits [3:0]
//   OVERFLOW  out  1               value did not fit in BCD_DIGITS digits
// -----------------------------------------------------------------------------
module binary_to_bcd_converter
  import binary_to_bcd_converter_pkg::*;
#(
  parameter int BIN_WIDTH     = 16,
  parameter int BCD_DIGITS    = 5,
  parameter int BLANK_LEADING = 0
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [BIN_WIDTH-1:0]    BIN_IN,
  input  logic                    START,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [BCD_DIGITS*4-1:0] BCD_OUT,
  output logic                    OVERFLOW
);

  localparam int                BCD_W    = BCD_DIGITS * 4;
  localparam int                CNT_W    = $clog2(BIN_WIDTH + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(BIN_WIDTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  state_t               state, state_next;
  logic [BIN_WIDTH-1:0] bin_reg;
  logic [BCD_W-1:0]     bcd_reg;
  logic [BCD_W-1:0]     bcd_adj;
  logic [BCD_W-1:0]     result;
  logic [CNT_W-1:0]     cnt;
  logic                 ovf_sticky;
  logic                 leading_zero;

  // Per-digit add-3 correction applied to the working register every shift.
  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .digit    (bcd_reg[g*4 +: 4]),
      .adjusted (bcd_adj[g*4 +: 4])
    );
  end

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= ST_IDLE;
    else          state <= state_next;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (START) state_next = ST_SHIFT;
      ST_SHIFT:  if (cnt == CNT_ONE) state_next = ST_FINISH;
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Final formatting: saturate on overflow, else optionally blank zero digits
  // above the most significant nonzero one. Digit 0 is always shown.
  always_comb begin
    result       = bcd_reg;
    leading_zero = 1'b1;
    if (ovf_sticky) begin
      result = {BCD_DIGITS{BCD_SAT_DIGIT}};
    end else if (BLANK_LEADING != 0) begin
      for (int i = BCD_DIGITS - 1; i > 0; i--) begin
        if (bcd_reg[i*4 +: 4] != 4'd0) leading_zero = 1'b0;
        if (leading_zero) result[i*4 +: 4] = BCD_BLANK_DIGIT;
      end
    end
  end

  // NOTE: the async reset clears every register, datapath included, so an
  // aborted conversion leaves no stale partial result behind.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      bin_reg    <= '0;
      bcd_reg    <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      BCD_OUT    <= '0;
      OVERFLOW   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (START) begin
            bin_reg    <= BIN_IN;
            bcd_reg    <= '0;
            cnt        <= CNT_LOAD;
            ovf_sticky <= 1'b0;
            BUSY       <= 1'b1;
          end
        end
        ST_SHIFT: begin
          // The bit leaving the top corrected digit means the value no longer
          // fits; it is remembered until the next accepted request.
          {bcd_reg, bin_reg} <= {bcd_adj[BCD_W-2:0], bin_reg, 1'b0};
          ovf_sticky         <= ovf_sticky | bcd_adj[BCD_W-1];
          cnt                <= cnt - CNT_ONE;
        end
        ST_FINISH: begin
          BCD_OUT  <= result;
          OVERFLOW <= ovf_sticky;
          DONE     <= 1'b1;
          BUSY     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule : binary_to_bcd_converter

// File: tb/tb_binary_to_bcd_converter.sv
// -----------------------------------------------------------------------------
// tb_binary_to_bcd_converter
// Three converters share clock, reset, START and BIN_IN:
//   dut_a  defaults (5 digits, no blanking)
//   dut_b  4 digits (exercises saturation/overflow)
//   dut_c  5 digits with leading-zero blanking
// Stimulus pushes hand-computed expectations into a scoreboard queue; an
// independent monitor pops and compares whenever dut_a pulses DONE.
// -----------------------------------------------------------------------------
module tb_binary_to_bcd_converter;

  localparam int NV = 8;

  typedef struct {
    logic [19:0] bcd5;
    logic [15:0] bcd4;
    logic        ovf4;
    logic [19:0] blank;
    int          issue_cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] bin_in;

  logic        busy_a, done_a, ovf_a;
  logic [19:0] bcd_a;
  logic        busy_b, done_b, ovf_b;
  logic [15:0] bcd_b;
  logic        busy_c, done_c, ovf_c;
  logic [19:0] bcd_c;

  // Directed vectors and hand-computed results.
  logic [15:0] vec_bin  [NV];
  logic [19:0] vec_bcd5 [NV];
  logic [15:0] vec_bcd4 [NV];
  logic        vec_ovf4 [NV];
  logic [19:0] vec_blank[NV];

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   busy_run = 0;
  logic done_prev = 1'b0;

  binary_to_bcd_converter #(.BIN_WIDTH(16), .BCD_DIGITS(5), .BLANK_LEADING(0)) dut_a (
    .CLK(clk), .RESET_N(rst_n), .BIN_IN(bin_in), .START(start),
    .BUSY(busy_a), .DONE(done_a), .BCD_OUT(bcd_a), .OVERFLOW(ovf_a)
  );

  binary_to_bcd_converter #(.BIN_WIDTH(16), .BCD_DIGITS(4), .BLANK_LEADING(0)) dut_b (
    .CLK(clk), .RESET_N(rst_n), .BIN_IN(bin_in), .START(start),
    .BUSY(busy_b), .DONE(done_b), .BCD_OUT(bcd_b), .OVERFLOW(ovf_b)
  );

  binary_to_bcd_converter #(.BIN_WIDTH(16), .BCD_DIGITS(5), .BLANK_LEADING(1)) dut_c (
    .CLK(clk), .RESET_N(rst_n), .BIN_IN(bin_in), .START(start),
    .BUSY(busy_c), .DONE(done_c), .BCD_OUT(bcd_c), .OVERFLOW(ovf_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, actual, expected, cyc);
  endtask

  task automatic push_vec(input int i);
    exp_t e;
    e.bcd5      = vec_bcd5[i];
    e.bcd4      = vec_bcd4[i];
    e.ovf4      = vec_ovf4[i];
    e.blank     = vec_blank[i];
    e.issue_cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy_a"}, 32'(busy_a), 0);
    check({tag, "_done_a"}, 32'(done_a), 0);
    check({tag, "_ovf_a"},  32'(ovf_a),  0);
    check({tag, "_bcd_a"},  32'(bcd_a),  0);
    check({tag, "_busy_b"}, 32'(busy_b), 0);
    check({tag, "_ovf_b"},  32'(ovf_b),  0);
    check({tag, "_bcd_b"},  32'(bcd_b),  0);
    check({tag, "_bcd_c"},  32'(bcd_c),  0);
  endtask

  // Called on a negedge: request vector i, poke START during the busy window
  // (must be ignored), then wait past DONE and confirm the result holds.
  task automatic run_vec(input int i);
    start  = 1'b1;
    bin_in = vec_bin[i];
    push_vec(i);
    @(negedge clk);
    start  = 1'b0;
    bin_in = 16'($urandom);
    repeat (3) @(negedge clk);
    start = 1'b1;
    repeat (4) begin
      bin_in = 16'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (11) @(negedge clk);
    check("hold_bcd_a", 32'(bcd_a), 32'(vec_bcd5[i]));
    check("hold_bcd_b", 32'(bcd_b), 32'(vec_bcd4[i]));
    check("hold_ovf_b", 32'(ovf_b), 32'(vec_ovf4[i]));
  endtask

  // Monitor: compares every DONE against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done_prev) check("done_single_cycle", 32'(done_a), 0);
      if (done_a) begin
        if (sb.size() == 0) begin
          check("spurious_done", 32'(done_a), 0);
        end else begin
          e = sb.pop_front();
          check("bcd_a",     32'(bcd_a),  32'(e.bcd5));
          check("ovf_a",     32'(ovf_a),  0);
          check("done_b",    32'(done_b), 1);
          check("bcd_b",     32'(bcd_b),  32'(e.bcd4));
          check("ovf_b",     32'(ovf_b),  32'(e.ovf4));
          check("done_c",    32'(done_c), 1);
          check("bcd_c",     32'(bcd_c),  32'(e.blank));
          check("ovf_c",     32'(ovf_c),  0);
          check("busy_low",  32'(busy_a), 0);
          check("latency",   32'(cyc - e.issue_cyc), 18);
          check("busy_cycles", 32'(busy_run), 17);
        end
      end
      done_prev = done_a;
      busy_run  = busy_a ? busy_run + 1 : 0;
    end
  end

  initial begin
    vec_bin[0] = 16'd1234;  vec_bcd5[0] = 20'h01234; vec_bcd4[0] = 16'h1234; vec_ovf4[0] = 1'b0; vec_blank[0] = 20'hF1234;
    vec_bin[1] = 16'hFFFF;  vec_bcd5[1] = 20'h65535; vec_bcd4[1] = 16'h9999; vec_ovf4[1] = 1'b1; vec_blank[1] = 20'h65535;
    vec_bin[2] = 16'd0;     vec_bcd5[2] = 20'h00000; vec_bcd4[2] = 16'h0000; vec_ovf4[2] = 1'b0; vec_blank[2] = 20'hFFFF0;
    vec_bin[3] = 16'd10000; vec_bcd5[3] = 20'h10000; vec_bcd4[3] = 16'h9999; vec_ovf4[3] = 1'b1; vec_blank[3] = 20'h10000;
    vec_bin[4] = 16'd42;    vec_bcd5[4] = 20'h00042; vec_bcd4[4] = 16'h0042; vec_ovf4[4] = 1'b0; vec_blank[4] = 20'hFFF42;
    vec_bin[5] = 16'd7;     vec_bcd5[5] = 20'h00007; vec_bcd4[5] = 16'h0007; vec_ovf4[5] = 1'b0; vec_blank[5] = 20'hFFFF7;
    vec_bin[6] = 16'd9999;  vec_bcd5[6] = 20'h09999; vec_bcd4[6] = 16'h9999; vec_ovf4[6] = 1'b0; vec_blank[6] = 20'hF9999;
    vec_bin[7] = 16'd100;   vec_bcd5[7] = 20'h00100; vec_bcd4[7] = 16'h0100; vec_ovf4[7] = 1'b0; vec_blank[7] = 20'hFF100;

    start  = 1'b0;
    bin_in = '0;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");

    // Release reset and request on the same negedge: first edge accepts.
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(0);
    for (int i = 1; i < NV; i++) begin
      @(negedge clk);
      run_vec(i);
    end

    // START held high with BIN_IN changing every cycle: accepts every 18.
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 54; k++) begin
      if (k % 18 == 0) begin
        case (k / 18)
          0:       begin bin_in = vec_bin[3]; push_vec(3); end
          1:       begin bin_in = vec_bin[4]; push_vec(4); end
          default: begin bin_in = vec_bin[1]; push_vec(1); end
        endcase
      end else begin
        bin_in = 16'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_abort_bcd_a", 32'(bcd_a), 32'h65535);

    // Abort a conversion after E5: outputs clear at once, no DONE follows.
    start  = 1'b1;
    bin_in = vec_bin[6];
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_busy_before", 32'(busy_a), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_vec(6);
    @(negedge clk);
    run_vec(7);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_binary_to_bcd_converter
